agu_pw_tracker: RTL and testbench

- Multi-outstanding page-walk tracker for the load/store AGU; successor to the single-walk `pageWalkActive`/`pageWalkAccepted` logic.
- Tracks up to NUM_WALKS concurrent DTLB-miss page walks and merges duplicate VPNs.
- Drives the page-walker request channel with per-slot request IDs and signals walk completion back so TLB-miss-queue entries can be woken.
- Sits between the AGU TLB-miss detection and the shared page walker.

---
 rtl/agu_pw_tracker.sv | 109 ++++++++++
 tb/tb_agu_pw_tracker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/agu_pw_tracker.sv
// agu_pw_tracker: multi-outstanding DTLB page-walk tracker with per-slot walker request IDs.
// Define AGU_PW_MERGE_EN to merge misses into a pending or issued walk of the same VPN.
module agu_pw_tracker #(
    parameter int NUM_WALKS = 2,
    parameter int VPN_W = 20,
    parameter int PPN_W = 22,
    parameter int RQ_BASE = 2,
    parameter int RQ_W = 4,
    localparam int SW = $clog2(NUM_WALKS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_missValid,
    input  logic [VPN_W-1:0] IN_missVpn,
    output logic             OUT_missAccept,
    output logic [SW-1:0]    OUT_missSlot,
    output logic             OUT_full,
    input  logic             IN_flush,
    input  logic [PPN_W-1:0] IN_rootPPN,
    output logic             OUT_pwValid,
    output logic [VPN_W-1:0] OUT_pwAddr,
    output logic [PPN_W-1:0] OUT_pwRootPPN,
    output logic [RQ_W-1:0]  OUT_pwRqID,
    input  logic             IN_pwBusy,
    input  logic [RQ_W-1:0]  IN_pwRqID,
    input  logic             IN_pwDone,
    output logic             OUT_doneValid,
    output logic [SW-1:0]    OUT_doneSlot
);
    typedef enum logic [1:0] {FREE, PENDING, ISSUED, ORPHAN} slot_st_t;
    slot_st_t st [NUM_WALKS];
    slot_st_t nxt [NUM_WALKS];
    logic [VPN_W-1:0] vpn [NUM_WALKS];
    logic [VPN_W-1:0] vpn_n [NUM_WALKS];
    logic hit, free_found, alloc, rq_match, req_found, done_found, full_n;
    logic [SW-1:0] hit_slot, free_slot, done_slot;
    logic [VPN_W-1:0] req_vpn;
    logic [RQ_W-1:0] req_rq;
    always_comb begin
        hit = 1'b0;
        hit_slot = '0;
        free_found = 1'b0;
        free_slot = '0;
        alloc = 1'b0;
        rq_match = 1'b0;
        req_found = 1'b0;
        req_vpn = '0;
        req_rq = '0;
        done_found = 1'b0;
        done_slot = '0;
        full_n = 1'b1;
        for (int i = NUM_WALKS - 1; i >= 0; i--) begin
            rq_match = IN_pwRqID == RQ_W'(RQ_BASE + i);
            nxt[i] = st[i];
            if (st[i] == PENDING && IN_pwBusy && rq_match) nxt[i] = ISSUED;
            if ((st[i] == ISSUED || st[i] == ORPHAN) && IN_pwDone && rq_match) nxt[i] = FREE;
            if (st[i] == ISSUED && IN_pwDone && rq_match && !IN_flush) begin
                done_found = 1'b1;
                done_slot = SW'(i);
            end
            if (IN_flush) nxt[i] = nxt[i] == PENDING ? FREE : nxt[i] == ISSUED ? ORPHAN : nxt[i];
`ifdef AGU_PW_MERGE_EN
            // a slot completing this cycle still merges: its TLB fill lands before the replay
            if (!IN_flush && (st[i] == PENDING || st[i] == ISSUED) && vpn[i] == IN_missVpn) begin
                hit = 1'b1;
                hit_slot = SW'(i);
            end
`endif
            if (nxt[i] == FREE) begin
                free_found = 1'b1;
                free_slot = SW'(i);
            end
        end
        alloc = IN_missValid && !hit && free_found;
        for (int i = NUM_WALKS - 1; i >= 0; i--) begin
            vpn_n[i] = vpn[i];
            if (alloc && free_slot == SW'(i)) begin
                nxt[i] = PENDING;
                vpn_n[i] = IN_missVpn;
            end
            if (nxt[i] == PENDING) begin
                req_found = 1'b1;
                req_vpn = vpn_n[i];
                req_rq = RQ_W'(RQ_BASE + i);
            end
            if (nxt[i] == FREE) full_n = 1'b0;
        end
    end
    assign OUT_missAccept = IN_missValid && (hit || free_found);
    assign OUT_missSlot = hit ? hit_slot : free_slot;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WALKS; i++) st[i] <= FREE;
            OUT_pwValid <= 1'b0;
            OUT_doneValid <= 1'b0;
            OUT_full <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WALKS; i++) st[i] <= nxt[i];
            OUT_pwValid <= req_found;
            OUT_doneValid <= done_found;
            OUT_full <= full_n;
        end
        for (int i = 0; i < NUM_WALKS; i++) vpn[i] <= vpn_n[i];
        OUT_pwAddr <= req_vpn;
        OUT_pwRootPPN <= IN_rootPPN;
        OUT_pwRqID <= req_rq;
        OUT_doneSlot <= done_slot;
    end
endmodule

// File: tb/tb_agu_pw_tracker.sv
// tb_agu_pw_tracker: directed vector table plus hand sequences for flush+miss and reset mid-walk.
module tb_agu_pw_tracker;
`ifdef AGU_PW_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif
    localparam logic [21:0] ROOT0 = 22'h2A0000;
    logic clk = 1'b0;
    logic rst, mv, flush, busy, dn;
    logic [19:0] mvpn;
    logic [21:0] root;
    logic [3:0] rq;
    logic acc, full, pv, dv;
    logic [1:0] mslot, dslot;
    logic [19:0] paddr;
    logic [21:0] proot;
    logic [3:0] prq;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    agu_pw_tracker dut (
        .clk(clk), .rst(rst),
        .IN_missValid(mv), .IN_missVpn(mvpn),
        .OUT_missAccept(acc), .OUT_missSlot(mslot), .OUT_full(full),
        .IN_flush(flush), .IN_rootPPN(root),
        .OUT_pwValid(pv), .OUT_pwAddr(paddr), .OUT_pwRootPPN(proot), .OUT_pwRqID(prq),
        .IN_pwBusy(busy), .IN_pwRqID(rq), .IN_pwDone(dn),
        .OUT_doneValid(dv), .OUT_doneSlot(dslot)
    );
    typedef struct {
        logic mv; logic [19:0] vpn; logic fl; logic busy; logic [3:0] rq; logic dn;
        logic e_acc; logic [1:0] e_slot; logic e_full;
        logic e_pv; logic [19:0] e_addr; logic [3:0] e_rq;
        logic e_dv; logic [1:0] e_ds;
    } vec_t;
    vec_t vt [42];
    function automatic vec_t V(input logic m, input logic [19:0] a, input logic f, input logic b,
                               input logic [3:0] r, input logic d, input logic ea, input logic [1:0] es,
                               input logic ef, input logic ep, input logic [19:0] ead, input logic [3:0] er,
                               input logic ed, input logic [1:0] eds);
        vec_t v;
        v.mv = m; v.vpn = a; v.fl = f; v.busy = b; v.rq = r; v.dn = d;
        v.e_acc = ea; v.e_slot = es; v.e_full = ef; v.e_pv = ep; v.e_addr = ead; v.e_rq = er;
        v.e_dv = ed; v.e_ds = eds;
        return v;
    endfunction
    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask
    task automatic idle();
        mv = 1'b0; mvpn = '0; flush = 1'b0; busy = 1'b0; rq = '0; dn = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        root = ROOT0;
        idle();
        // basic walk
        vt[0]  = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0,        0,  0, 0);
        vt[1]  = V(1, 'h12345,  0, 0, 0, 0,  1, 0, 0,  0, 0,        0,  0, 0);
        vt[2]  = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  1, 'h12345,  2,  0, 0);
        vt[3]  = V(0, 0,        0, 1, 2, 0,  0, 0, 0,  1, 'h12345,  2,  0, 0);
        vt[4]  = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0,        0,  0, 0);
        vt[5]  = V(0, 0,        0, 0, 2, 1,  0, 0, 0,  0, 0,        0,  0, 0);
        vt[6]  = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0,        0,  1, 0);
        vt[7]  = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0,        0,  0, 0);
        // duplicate VPN: merged with merging, a second walk without
        vt[8]  = V(1, 'hAAAAA,  0, 0, 0, 0,  1, 0, 0,  0, 0,        0,  0, 0);
        vt[9]  = V(1, 'hAAAAA,  0, 0, 0, 0,  1, MERGE ? 2'd0 : 2'd1, 0,  1, 'hAAAAA, 2, 0, 0);
        vt[10] = V(0, 0,        0, 1, 2, 0,  0, 0, !MERGE,  1, 'hAAAAA,  2,  0, 0);
        vt[11] = V(0, 0,        0, 1, 3, 0,  0, 0, !MERGE,  !MERGE, 'hAAAAA, 3, 0, 0);
        vt[12] = V(0, 0,        0, 0, 2, 1,  0, 0, !MERGE,  0, 0,   0,  0, 0);
        vt[13] = V(0, 0,        0, 0, 3, 1,  0, 0, 0,  0, 0,        0,  1, 0);
        vt[14] = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0,        0,  !MERGE, 1);
        // fill both slots, third miss stalls until a walk completes
        vt[15] = V(1, 'h1,      0, 0, 0, 0,  1, 0, 0,  0, 0,        0,  0, 0);
        vt[16] = V(1, 'h2,      0, 0, 0, 0,  1, 1, 0,  1, 'h1,      2,  0, 0);
        vt[17] = V(1, 'h3,      0, 1, 2, 0,  0, 0, 1,  1, 'h1,      2,  0, 0);
        vt[18] = V(1, 'h3,      0, 1, 3, 0,  0, 0, 1,  1, 'h2,      3,  0, 0);
        vt[19] = V(0, 0,        0, 0, 2, 1,  0, 0, 1,  0, 0,        0,  0, 0);
        vt[20] = V(1, 'h3,      0, 0, 0, 0,  1, 0, 0,  0, 0,        0,  1, 0);
        vt[21] = V(0, 0,        0, 1, 2, 0,  0, 0, 1,  1, 'h3,      2,  0, 0);
        vt[22] = V(0, 0,        0, 0, 3, 1,  0, 0, 1,  0, 0,        0,  0, 0);
        vt[23] = V(0, 0,        0, 0, 2, 1,  0, 0, 0,  0, 0,        0,  1, 1);
        vt[24] = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0,        0,  1, 0);
        // flush with slot 0 issued and slot 1 pending
        vt[25] = V(1, 'h100,    0, 0, 0, 0,  1, 0, 0,  0, 0,        0,  0, 0);
        vt[26] = V(0, 0,        0, 1, 2, 0,  0, 0, 0,  1, 'h100,    2,  0, 0);
        vt[27] = V(1, 'h200,    0, 0, 0, 0,  1, 1, 0,  0, 0,        0,  0, 0);
        vt[28] = V(0, 0,        1, 0, 0, 0,  0, 0, 1,  1, 'h200,    3,  0, 0);
        vt[29] = V(0, 0,        0, 0, 2, 1,  0, 0, 0,  0, 0,        0,  0, 0);
        vt[30] = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0,        0,  0, 0);
        vt[31] = V(1, 'h300,    0, 0, 0, 0,  1, 0, 0,  0, 0,        0,  0, 0);
        vt[32] = V(0, 0,        0, 1, 2, 0,  0, 0, 0,  1, 'h300,    2,  0, 0);
        vt[33] = V(0, 0,        0, 0, 2, 1,  0, 0, 0,  0, 0,        0,  0, 0);
        vt[34] = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0,        0,  1, 0);
        // completion coinciding with a miss of the same VPN
        vt[35] = V(1, 'h4567,   0, 0, 0, 0,  1, 0, 0,  0, 0,        0,  0, 0);
        vt[36] = V(0, 0,        0, 1, 2, 0,  0, 0, 0,  1, 'h4567,   2,  0, 0);
        vt[37] = V(1, 'h4567,   0, 0, 2, 1,  1, 0, 0,  0, 0,        0,  0, 0);
        vt[38] = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  !MERGE, 'h4567, 2, 1, 0);
        vt[39] = V(0, 0,        0, 1, 2, 0,  0, 0, 0,  !MERGE, 'h4567, 2, 0, 0);
        vt[40] = V(0, 0,        0, 0, 2, 1,  0, 0, 0,  0, 0,        0,  0, 0);
        vt[41] = V(0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0,        0,  !MERGE, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 42; k++) begin
            mv = vt[k].mv; mvpn = vt[k].vpn; flush = vt[k].fl;
            busy = vt[k].busy; rq = vt[k].rq; dn = vt[k].dn;
            root = ROOT0 + 22'(k);
            #1;
            chk("missAccept", k, 32'(acc), 32'(vt[k].e_acc));
            if (vt[k].e_acc) chk("missSlot", k, 32'(mslot), 32'(vt[k].e_slot));
            chk("full", k, 32'(full), 32'(vt[k].e_full));
            chk("pwValid", k, 32'(pv), 32'(vt[k].e_pv));
            if (vt[k].e_pv) begin
                chk("pwAddr", k, 32'(paddr), 32'(vt[k].e_addr));
                chk("pwRqID", k, 32'(prq), 32'(vt[k].e_rq));
                chk("pwRootPPN", k, 32'(proot), 32'(ROOT0 + 22'(k - 1)));
            end
            chk("doneValid", k, 32'(dv), 32'(vt[k].e_dv));
            if (vt[k].e_dv) chk("doneSlot", k, 32'(dslot), 32'(vt[k].e_ds));
            @(negedge clk);
        end
        // miss with flush never merges into the flushed (now orphaned) slot
        idle(); mv = 1'b1; mvpn = 20'h777;
        #1 chk("fm_acc0", 100, 32'(acc), 32'd1);
        chk("fm_slot0", 100, 32'(mslot), 32'd0);
        @(negedge clk);
        idle(); busy = 1'b1; rq = 4'd2;
        @(negedge clk);
        idle(); flush = 1'b1; mv = 1'b1; mvpn = 20'h777;
        #1 chk("fm_acc1", 101, 32'(acc), 32'd1);
        chk("fm_slot1", 101, 32'(mslot), 32'd1);
        @(negedge clk);
        idle(); busy = 1'b1; rq = 4'd3;
        #1 chk("fm_pv", 102, 32'(pv), 32'd1);
        chk("fm_addr", 102, 32'(paddr), 32'h777);
        chk("fm_rq", 102, 32'(prq), 32'd3);
        chk("fm_full", 102, 32'(full), 32'd1);
        @(negedge clk);
        idle(); dn = 1'b1; rq = 4'd2;
        #1 chk("fm_pv_off", 103, 32'(pv), 32'd0);
        chk("fm_full2", 103, 32'(full), 32'd1);
        @(negedge clk);
        idle(); dn = 1'b1; rq = 4'd3;
        #1 chk("fm_orphan_nodone", 104, 32'(dv), 32'd0);
        chk("fm_full3", 104, 32'(full), 32'd0);
        @(negedge clk);
        idle();
        #1 chk("fm_dv", 105, 32'(dv), 32'd1);
        chk("fm_ds", 105, 32'(dslot), 32'd1);
        @(negedge clk);
        // reset while two walks are issued, then a late completion
        idle(); mv = 1'b1; mvpn = 20'h11;
        @(negedge clk);
        idle(); mv = 1'b1; mvpn = 20'h22;
        @(negedge clk);
        idle(); busy = 1'b1; rq = 4'd2;
        @(negedge clk);
        idle(); busy = 1'b1; rq = 4'd3;
        @(negedge clk);
        idle();
        #1 chk("rs_full_pre", 110, 32'(full), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dn = 1'b1; rq = 4'd2;
        #1 chk("rs_pv", 111, 32'(pv), 32'd0);
        chk("rs_dv", 111, 32'(dv), 32'd0);
        chk("rs_full", 111, 32'(full), 32'd0);
        @(negedge clk);
        idle(); mv = 1'b1; mvpn = 20'h55;
        #1 chk("rs_late_done", 112, 32'(dv), 32'd0);
        chk("rs_acc", 112, 32'(acc), 32'd1);
        chk("rs_slot", 112, 32'(mslot), 32'd0);
        @(negedge clk);
        idle();
        #1 chk("rs_req", 113, 32'(pv), 32'd1);
        chk("rs_addr", 113, 32'(paddr), 32'h55);
        chk("rs_rq", 113, 32'(prq), 32'd2);
        chk("rs_full2", 113, 32'(full), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
